// File: rtl/delta_decompression.sv
// Serial delta/literal token decoder: rebuilds words from a flag+payload bit stream,
// adding sign-extended deltas to the last word handed to the consumer.
module delta_decompression #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    DELTA_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] STARTER     = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_literal
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {HEADER, LITERAL, DELTA, HOLD} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] prev;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [DATA_WIDTH-1:0] delta_ext;
  logic [DATA_WIDTH-1:0] delta_sum;
  logic                  accept;

  assign in_ready  = (state != HOLD);
  assign accept    = in_valid && in_ready;
  assign shift_nxt = {shift_q[DATA_WIDTH-2:0], in};
  // The delta sits in the low bits of the shift register, including the bit arriving now.
  assign delta_ext = DATA_WIDTH'($signed(shift_nxt[DELTA_WIDTH-1:0]));
  assign delta_sum = prev + delta_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HEADER;
      bit_cnt     <= '0;
      shift_q     <= '0;
      prev        <= STARTER;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_literal <= 1'b0;
    end else begin
      case (state)
        HEADER: begin
          if (accept) begin
            state   <= in ? LITERAL : DELTA;
            bit_cnt <= '0;
            shift_q <= '0;
          end
        end
        LITERAL: begin
          if (accept) begin
            shift_q <= shift_nxt;
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
              out_data    <= shift_nxt;
              out_literal <= 1'b1;
              out_valid   <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        DELTA: begin
          if (accept) begin
            shift_q <= shift_nxt;
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(DELTA_WIDTH - 1)) begin
              out_data    <= delta_sum;
              out_literal <= 1'b0;
              out_valid   <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          // Prediction base advances only once the consumer has taken the word.
          if (out_ready) begin
            prev      <= out_data;
            out_valid <= 1'b0;
            state     <= HEADER;
          end
        end
        default: state <= HEADER;
      endcase
    end
  end

endmodule

// File: tb/tb_delta_decompression.sv
// Scoreboard bench for delta_decompression: tokens push expected words, observed
// transfers are collected per cycle and compared in each scenario task.
module tb_delta_decompression;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       in_ready;
  logic       out_valid;
  logic       out_literal;
  logic [7:0] out_data;

  typedef struct packed {logic lit; logic [7:0] d;} word_t;

  word_t exp_q[$];
  word_t obs_q[$];
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  delta_decompression dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_literal(out_literal)
  );

  // One cycle: record a transfer that the coming edge completes, then advance.
  task automatic step();
    if (out_valid && out_ready && !reset) obs_q.push_back({out_literal, out_data});
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      int g;
      int t;
      bit acc;
      g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
      in_valid = 1'b0;
      repeat (g) step();
      in_valid = 1'b1;
      in = v[n-1-i];
      t = 0;
      do begin
        acc = in_ready;
        step();
        t++;
      end while (!acc && t < 50);
      if (!acc) begin
        tests++; fails++;
        $display("FAIL accept_timeout: bit %0d not accepted, in_ready=%b required 1", i, in_ready);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_lit(input logic [7:0] d, input int gap);
    exp_q.push_back({1'b1, d});
    send_bits({7'b0, 1'b1, d}, 9, gap);
  endtask

  task automatic send_delta(input logic [3:0] dl, input logic [7:0] expv, input int gap);
    exp_q.push_back({1'b0, expv});
    send_bits({11'b0, 1'b0, dl}, 5, gap);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h required 00", out_data); end
    tests++; if (out_literal !== 1'b0) begin fails++; $display("FAIL reset_out_literal: got %b required 0", out_literal); end
    reset = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    step();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
  endtask

  task automatic test_stream(input int gap);
    do_reset();
    send_lit(8'hA5, gap);
    tests++; if (out_valid !== 1'b1 || out_literal !== 1'b1) begin
      fails++; $display("FAIL lit_valid_timing: valid=%b lit=%b required 1 1 (gap %0d)", out_valid, out_literal, gap);
    end
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lit_valid_width: got %b required 0 (gap %0d)", out_valid, gap); end
    send_delta(4'h3, 8'hA8, gap);
    send_delta(4'hE, 8'hA6, gap);
    repeat (3) step();
    while (exp_q.size() > 0) begin
      word_t e, o;
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL stream_missing: no transfer, required %h (gap %0d)", e, gap); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL stream_word: got %h required %h (gap %0d)", o, e, gap); end end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL stream_extra: %0d extra words, required 0", obs_q.size()); end
  endtask

  task automatic test_wrap(input int gap);
    do_reset();
    send_delta(4'hF, 8'hFF, gap);
    send_delta(4'h1, 8'h00, gap);
    repeat (3) step();
    while (exp_q.size() > 0) begin
      word_t e, o;
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL wrap_missing: no transfer, required %h (gap %0d)", e, gap); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL wrap_word: got %h required %h (gap %0d)", o, e, gap); end end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL wrap_extra: %0d extra words, required 0", obs_q.size()); end
  endtask

  task automatic test_back_to_back_hold();
    do_reset();
    out_ready = 1'b0;
    send_delta(4'h2, 8'h02, 0);
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in = 1'b1;
      tests++; if (out_valid !== 1'b1 || out_data !== 8'h02 || in_ready !== 1'b0) begin
        fails++; $display("FAIL hold_cycle%0d: valid=%b data=%h in_ready=%b required 1 02 0", c, out_valid, out_data, in_ready);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL hold_release: valid=%b required 0", out_valid); end
    send_delta(4'h1, 8'h03, 0);
    repeat (3) step();
    while (exp_q.size() > 0) begin
      word_t e, o;
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL hold_missing: no transfer, required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL hold_word: got %h required %h", o, e); end end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL hold_extra: %0d extra words, required 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid_token();
    do_reset();
    send_bits(16'b1101, 4, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL midreset_state: valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    repeat (3) step();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_no_word: valid=%b required 0", out_valid); end
    send_delta(4'h2, 8'h02, 0);
    repeat (3) step();
    while (exp_q.size() > 0) begin
      word_t e, o;
      e = exp_q.pop_front();
      tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL midreset_missing: no transfer, required %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin fails++; $display("FAIL midreset_word: got %h required %h", o, e); end end
    end
    tests++; if (obs_q.size() != 0) begin fails++; $display("FAIL midreset_extra: %0d extra words, required 0", obs_q.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream(0);
    test_wrap(0);
    test_back_to_back_hold();
    test_reset_mid_token();
    test_stream(3);
    test_wrap(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
